// File: rtl/screen_pkg.sv
// Shared types and constants for the screen sequencer.
// Optional frame-stepped fade is enabled with SCREEN_FADE_EN.
package screen_pkg;

    typedef enum logic [2:0] {
        S_TITLE    = 3'd0,
        S_CONTROLS = 3'd1,
        S_GAME     = 3'd2,
        S_OVER     = 3'd3,
        S_WIN      = 3'd4
    } screen_e;

    typedef enum logic [1:0] {
        PH_STEADY = 2'd0,
        PH_OUT    = 2'd1,
        PH_IN     = 2'd2
    } phase_e;

    localparam logic [7:0] KEY_ENTER_DEF = 8'h28;
    localparam logic [7:0] KEY_CTRL_DEF  = 8'h06;
    localparam logic [7:0] KEY_ESC_DEF   = 8'h29;

    localparam int         FADE_W    = 5;
    localparam logic [4:0] LEVEL_MAX = 5'd16;

endpackage

// File: rtl/screen_fade.sv
// Per-channel brightness scale: (c * level) >> 4, level 0..16.
// Level 16 passes the channel through unchanged.
module screen_fade
    import screen_pkg::*;
(
    input  logic [3:0]        c_i,
    input  logic [FADE_W-1:0] level_i,
    output logic [3:0]        c_o
);

    logic [7:0] prod;

    assign prod = 8'(c_i) * 8'(level_i);
    assign c_o  = 4'(prod >> 4);

endmodule

// File: rtl/screen_sequencer.sv
// Screen state tracking, transition sequencing and final pixel register.
// Define SCREEN_FADE_EN for a fade-out/fade-in on every transition.
module screen_sequencer
    import screen_pkg::*;
#(
    parameter int         V_ACTIVE    = 480,
    parameter int         HOLD_FRAMES = 600,
    parameter logic [7:0] KEY_ENTER   = KEY_ENTER_DEF,
    parameter logic [7:0] KEY_CTRL    = KEY_CTRL_DEF,
    parameter logic [7:0] KEY_ESC     = KEY_ESC_DEF
) (
    input  logic             vga_clk,
    input  logic             reset,
    input  logic [9:0]       DrawX,
    input  logic [9:0]       DrawY,
    input  logic             blank,
    input  logic             key_valid,
    input  logic [7:0]       keycode,
    input  logic             game_over_evt,
    input  logic             win_evt,
    input  logic [4:0][11:0] scr_rgb,
    output logic [2:0]       screen_sel,
    output logic             game_start,
    output logic             busy,
    output logic [3:0]       red,
    output logic [3:0]       green,
    output logic [3:0]       blue
);

    screen_e           scr_q, prev_q, tgt_q, req_tgt;
    phase_e            phase_q;
    logic [FADE_W-1:0] level_q;
    logic              pend_q, gs_q;
    logic [9:0]        hold_q;
    logic [3:0]        red_q, green_q, blue_q;
    logic              frame_tick, req_v, sw, end_scr;
    logic              k_enter, k_ctrl, k_esc;
    logic [11:0]       sel;
    logic [3:0]        r_s, g_s, b_s;

    assign frame_tick = (DrawX == 10'd0) && (DrawY == 10'(V_ACTIVE));
    assign k_enter    = key_valid && (keycode == KEY_ENTER);
    assign k_ctrl     = key_valid && (keycode == KEY_CTRL);
    assign k_esc      = key_valid && (keycode == KEY_ESC);
    assign end_scr    = (scr_q == S_OVER) || (scr_q == S_WIN);

`ifdef SCREEN_FADE_EN
    assign sw = (phase_q == PH_OUT) && frame_tick && (level_q == '0);
`else
    assign sw = pend_q && frame_tick;
`endif

    always_comb begin
        req_v   = 1'b0;
        req_tgt = S_TITLE;
        if (phase_q == PH_STEADY && !pend_q) begin
            unique case (scr_q)
                S_TITLE: begin
                    if (k_enter) begin
                        req_v   = 1'b1;
                        req_tgt = S_GAME;
                    end else if (k_ctrl) begin
                        req_v   = 1'b1;
                        req_tgt = S_CONTROLS;
                    end
                end
                S_CONTROLS: req_v = k_esc || k_enter;
                S_GAME: begin
                    // Loss takes priority over a same-cycle win
                    if (game_over_evt) begin
                        req_v   = 1'b1;
                        req_tgt = S_OVER;
                    end else if (win_evt) begin
                        req_v   = 1'b1;
                        req_tgt = S_WIN;
                    end
                end
                S_OVER, S_WIN:
                    req_v = k_enter || (hold_q >= 10'(HOLD_FRAMES));
                default: req_v = 1'b0;
            endcase
        end
    end

    assign sel = scr_rgb[scr_q];

    screen_fade u_fade_r (.c_i(sel[11:8]), .level_i(level_q), .c_o(r_s));
    screen_fade u_fade_g (.c_i(sel[7:4]),  .level_i(level_q), .c_o(g_s));
    screen_fade u_fade_b (.c_i(sel[3:0]),  .level_i(level_q), .c_o(b_s));

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            scr_q   <= S_TITLE;
            prev_q  <= S_TITLE;
            tgt_q   <= S_TITLE;
            phase_q <= PH_STEADY;
            level_q <= LEVEL_MAX;
            pend_q  <= 1'b0;
            hold_q  <= '0;
            gs_q    <= 1'b0;
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
        end else begin
            prev_q  <= scr_q;
            gs_q    <= (scr_q == S_GAME) && (prev_q != S_GAME);
            red_q   <= blank ? r_s : 4'd0;
            green_q <= blank ? g_s : 4'd0;
            blue_q  <= blank ? b_s : 4'd0;
            if (sw) begin
                scr_q  <= tgt_q;
                hold_q <= '0;
            end else if (frame_tick && end_scr && hold_q != '1) begin
                hold_q <= hold_q + 10'd1;
            end
`ifdef SCREEN_FADE_EN
            unique case (phase_q)
                PH_STEADY: begin
                    if (req_v) begin
                        phase_q <= PH_OUT;
                        tgt_q   <= req_tgt;
                    end
                end
                PH_OUT: begin
                    if (frame_tick) begin
                        if (level_q == '0) phase_q <= PH_IN;
                        else               level_q <= level_q - 5'd1;
                    end
                end
                PH_IN: begin
                    if (frame_tick) begin
                        level_q <= level_q + 5'd1;
                        if (level_q == LEVEL_MAX - 5'd1) phase_q <= PH_STEADY;
                    end
                end
                default: phase_q <= PH_STEADY;
            endcase
`else
            if (req_v) begin
                pend_q <= 1'b1;
                tgt_q  <= req_tgt;
            end else if (sw) begin
                pend_q <= 1'b0;
            end
`endif
        end
    end

    assign screen_sel = scr_q;
    assign game_start = gs_q;
    assign busy       = (phase_q != PH_STEADY) || pend_q;
    assign red        = red_q;
    assign green      = green_q;
    assign blue       = blue_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// Directed bench for screen_sequencer, valid with or without SCREEN_FADE_EN.
module tb_screen_sequencer;

`ifdef SCREEN_FADE_EN
    localparam int TR = 33;
    localparam int SW = 17;
    localparam int RF = 11;
`else
    localparam int TR = 1;
    localparam int SW = 1;
    localparam int RF = 0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [9:0]       DrawX = 10'd1;
    logic [9:0]       DrawY = 10'd0;
    logic             blank = 1'b1;
    logic             key_valid = 1'b0;
    logic [7:0]       keycode = 8'h00;
    logic             game_over_evt = 1'b0;
    logic             win_evt = 1'b0;
    logic [4:0][11:0] scr_rgb = '0;
    logic [2:0]       screen_sel;
    logic             game_start, busy;
    logic [3:0]       red, green, blue;

    int checks = 0;
    int errors = 0;

    screen_sequencer #(.HOLD_FRAMES(4)) dut (
        .vga_clk(clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY),
        .blank(blank), .key_valid(key_valid), .keycode(keycode),
        .game_over_evt(game_over_evt), .win_evt(win_evt),
        .scr_rgb(scr_rgb), .screen_sel(screen_sel),
        .game_start(game_start), .busy(busy),
        .red(red), .green(green), .blue(blue)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        bl;
        logic [11:0] rgb;
        logic [11:0] exp;
    } vec_t;

    vec_t tv[6];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        DrawX = 10'd0;
        DrawY = 10'd480;
        cyc();
        DrawX = 10'd1;
        DrawY = 10'd0;
    endtask

    task automatic run_frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame();
            cyc();
        end
    endtask

    task automatic key(input logic [7:0] k);
        key_valid = 1'b1;
        keycode   = k;
        cyc();
        key_valid = 1'b0;
    endtask

    function automatic int lvl_at(input int f);
`ifdef SCREEN_FADE_EN
        if (f <= 16) return 16 - f;
        if (f == 17) return 0;
        return f - 17;
`else
        return 16 + 0 * f;
`endif
    endfunction

    initial begin
        tv[0] = '{1'b1, 12'hF84, 12'hF84};
        tv[1] = '{1'b0, 12'hF84, 12'h000};
        tv[2] = '{1'b1, 12'h123, 12'h123};
        tv[3] = '{1'b1, 12'hFFF, 12'hFFF};
        tv[4] = '{1'b1, 12'h000, 12'h000};
        tv[5] = '{1'b0, 12'hA5C, 12'h000};

        scr_rgb[0] = 12'hF84;
        scr_rgb[2] = 12'h777;
        cyc();
        cyc();
        chk("rst_sel", 32'(screen_sel), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_gs", 32'(game_start), 0);
        chk("rst_rgb", {20'd0, red, green, blue}, 0);
        reset = 1'b0;
        cyc();

        for (int i = 0; i < 6; i++) begin
            blank      = tv[i].bl;
            scr_rgb[0] = tv[i].rgb;
            cyc();
            chk($sformatf("pix%0d", i), {20'd0, red, green, blue},
                32'(tv[i].exp));
        end
        blank = 1'b1;

        key(8'h29);
        chk("title_esc_drop", 32'(busy), 0);
        key(8'h11);
        chk("title_other_drop", 32'(busy), 0);

        key(8'h28);
        chk("start_busy", 32'(busy), 1);
        cyc();
        cyc();
        chk("start_no_midframe", 32'(screen_sel), 0);
        run_frames(SW - 1);
        chk("start_pre_sw", 32'(screen_sel), 0);
        frame();
        chk("start_sel", 32'(screen_sel), 2);
        chk("start_gs0", 32'(game_start), 0);
        cyc();
        chk("start_gs1", 32'(game_start), 1);
        cyc();
        chk("start_gs2", 32'(game_start), 0);
        run_frames(TR - SW);
        chk("start_done", 32'(busy), 0);

        key(8'h28);
        chk("game_key_drop", 32'(busy), 0);
        game_over_evt = 1'b1;
        win_evt       = 1'b1;
        cyc();
        game_over_evt = 1'b0;
        win_evt       = 1'b0;
        chk("evt_busy", 32'(busy), 1);
        win_evt = 1'b1;
        cyc();
        win_evt = 1'b0;
        run_frames(SW);
        chk("evt_over", 32'(screen_sel), 3);
        run_frames(TR - SW);
        chk("evt_done", 32'(busy), 0);

`ifdef SCREEN_FADE_EN
        cyc();
        chk("hold_busy", 32'(busy), 1);
        run_frames(SW);
        chk("hold_title", 32'(screen_sel), 0);
        run_frames(TR - SW);
`else
        key(8'h06);
        chk("over_ctrl_drop", 32'(busy), 0);
        run_frames(3);
        chk("hold_3_sel", 32'(screen_sel), 3);
        chk("hold_3_busy", 32'(busy), 0);
        frame();
        cyc();
        chk("hold_4_busy", 32'(busy), 1);
        frame();
        chk("hold_title", 32'(screen_sel), 0);
`endif
        chk("hold_done", 32'(busy), 0);

        scr_rgb[0] = 12'hFFF;
        scr_rgb[1] = 12'hFFF;
        key(8'h06);
        chk("ctrl_busy", 32'(busy), 1);
        for (int f = 1; f <= TR; f++) begin
            frame();
            cyc();
            chk($sformatf("ramp_r%0d", f), 32'(red), 32'((15 * lvl_at(f)) >> 4));
            chk($sformatf("ramp_b%0d", f), 32'(blue), 32'((15 * lvl_at(f)) >> 4));
            chk($sformatf("ramp_sel%0d", f), 32'(screen_sel),
                (f < SW) ? 32'd0 : 32'd1);
        end
        chk("ctrl_done", 32'(busy), 0);

        key(8'h29);
        chk("esc_busy", 32'(busy), 1);
        run_frames(RF);
        cyc();
        chk("mid_r", 32'(red), 32'((15 * lvl_at(RF)) >> 4));
        chk("mid_sel", 32'(screen_sel), 1);
        reset = 1'b1;
        #1;
        chk("arst_sel", 32'(screen_sel), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_rgb", {20'd0, red, green, blue}, 0);
        chk("arst_gs", 32'(game_start), 0);
        reset = 1'b0;
        cyc();
        cyc();
        chk("post_rst_rgb", {20'd0, red, green, blue}, 32'h0FFF);
        chk("post_rst_busy", 32'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
